// File: rtl/mips_io_pkg.sv
// mips_io_pkg: address map and register field positions for the MIPS I/O bridge.
package mips_io_pkg;

    // Word addresses on the 7-bit CPU address bus
    localparam logic [6:0] IO_BASE = 7'h78;
    localparam logic [6:0] LED_A   = 7'h78;
    localparam logic [6:0] SW_A    = 7'h79;
    localparam logic [6:0] TCTRL_A = 7'h7A;
    localparam logic [6:0] TSTAT_A = 7'h7B;

    // TCTRL / TSTAT field positions
    localparam int unsigned TCTRL_EN_BIT     = 31;
    localparam int unsigned TCTRL_RELOAD_MSB = 15;
    localparam int unsigned TCTRL_RELOAD_LSB = 0;

    // Anything at or above IO_BASE belongs to the bridge rather than the RAM
    function automatic logic is_io_addr(logic [6:0] addr);
        return addr >= IO_BASE;
    endfunction

endpackage

// File: rtl/io_timer.sv
// io_timer: prescaled down-counter with auto-reload and sticky FLAG.
// State updates on the falling edge of CLK; RST is synchronous, active-high.
module io_timer
    import mips_io_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_i,      // TCTRL write strobe
    input  logic [31:0] wdata_i,
    input  logic        rd_clr_i,  // TSTAT read, clears FLAG
    output logic        en_o,
    output logic [15:0] reload_o,
    output logic [15:0] count_o,
    output logic        flag_o
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic        en_q, en_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic [15:0] presc_q, presc_d;
    logic        tick;
    logic        flag_set;
    logic        unused_wdata;

    assign unused_wdata = ^wdata_i[30:16];

    // Next-state: a TCTRL write takes priority over (and swallows) a coincident tick
    always_comb begin
        en_d     = en_q;
        reload_d = reload_q;
        count_d  = count_q;
        flag_set = 1'b0;
        tick     = en_q && (presc_q == PRESC_LAST) && !wr_i;

        if (!en_q || wr_i || presc_q == PRESC_LAST) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 16'd1;
        end

        if (wr_i) begin
            en_d     = wdata_i[TCTRL_EN_BIT];
            reload_d = wdata_i[TCTRL_RELOAD_MSB:TCTRL_RELOAD_LSB];
            count_d  = wdata_i[TCTRL_RELOAD_MSB:TCTRL_RELOAD_LSB];
        end else if (tick) begin
            // COUNT==0 only arises with RELOAD==0: the timer parks there
            if (count_q == 16'd1) begin
                count_d  = reload_q;
                flag_set = 1'b1;
            end else if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end
        end

        // A set on the same edge as a read-clear must not be lost
        flag_d = flag_q;
        if (rd_clr_i) begin
            flag_d = 1'b0;
        end
        if (flag_set) begin
            flag_d = 1'b1;
        end
    end

    // Timer state registers, falling edge like the RAM
    always_ff @(negedge CLK) begin
        if (RST) begin
            en_q     <= 1'b0;
            reload_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            presc_q  <= '0;
        end else begin
            en_q     <= en_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            presc_q  <= presc_d;
        end
    end

    assign en_o     = en_q;
    assign reload_o = reload_q;
    assign count_o  = count_q;
    assign flag_o   = flag_q;

endmodule

// File: rtl/mips_io_bridge.sv
// mips_io_bridge: splits the CPU bus between RAM (0x00-0x77) and memory-mapped I/O
// (LED, SW, optional timer). Define IO_TIMER_EN to build the timer at 0x7A/0x7B;
// without it those addresses behave as reserved and IRQ is tied low.
module mips_io_bridge
    import mips_io_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        WE,
    input  logic [6:0]  ADDR,
    inout  wire  [31:0] Mem_Bus,
    output logic        RAM_CS,
    input  logic [7:0]  SW,
    output logic [7:0]  LED,
    output logic        IRQ
);

    logic        is_io;
    logic        io_rd;
    logic        io_wr;
    logic [7:0]  led_q, led_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [31:0] rdata_q, rdata_d;

`ifdef IO_TIMER_EN
    logic        tmr_en;
    logic [15:0] tmr_reload;
    logic [15:0] tmr_count;
    logic        tmr_flag;
`else
    logic        unused_bus;
    assign unused_bus = ^Mem_Bus[31:8];
`endif

    assign is_io  = is_io_addr(ADDR);
    assign io_rd  = CS && !WE && is_io;
    assign io_wr  = CS && WE && is_io;
    assign RAM_CS = CS && !is_io;

    // Bridge drives the shared bus only while an I/O read is presented
    assign Mem_Bus = io_rd ? rdata_q : {32{1'bz}};

    // Read mux and LED write decode
    always_comb begin
        rdata_d = rdata_q;
        led_d   = led_q;
        if (io_rd) begin
            case (ADDR)
                LED_A:   rdata_d = {24'b0, led_q};
                SW_A:    rdata_d = {24'b0, sw_sync_q};
`ifdef IO_TIMER_EN
                TCTRL_A: rdata_d = {tmr_en, 15'b0, tmr_reload};
                TSTAT_A: rdata_d = {tmr_flag, 15'b0, tmr_count};
`endif
                default: rdata_d = '0;
            endcase
        end
        if (io_wr && ADDR == LED_A) begin
            led_d = Mem_Bus[7:0];
        end
    end

    // Bridge registers, falling edge; reset overrides any same-edge access
    always_ff @(negedge CLK) begin
        if (RST) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            rdata_q   <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            rdata_q   <= rdata_d;
        end
    end

    assign LED = led_q;

`ifdef IO_TIMER_EN
    io_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .wr_i     (io_wr && ADDR == TCTRL_A),
        .wdata_i  (Mem_Bus),
        .rd_clr_i (io_rd && ADDR == TSTAT_A),
        .en_o     (tmr_en),
        .reload_o (tmr_reload),
        .count_o  (tmr_count),
        .flag_o   (tmr_flag)
    );

    assign IRQ = tmr_flag;
`else
    assign IRQ = 1'b0;
`endif

endmodule

// File: doc/mips_io_bridge.md
MIPS_IO_BRIDGE -- requirements
Module: mips_io_bridge

Interface
REQ-001 CLK  input  1  system clock; all bridge state updates on the falling edge of CLK, matching the RAM timing.
REQ-002 RST  input  1  reset, synchronous, active-high.
REQ-003 CS  input  1  CPU chip select.
REQ-004 WE  input  1  CPU write enable; meaningful only when CS=1.
REQ-005 ADDR  input  7  CPU word address.
REQ-006 Mem_Bus  inout  32  shared CPU/RAM data bus; bridge drives it only during I/O reads.
REQ-007 RAM_CS  output  1  chip select to the RAM.
REQ-008 SW  input  8  asynchronous board switches.
REQ-009 LED  output  8  LED register contents.
REQ-010 IRQ  output  1  timer flag, level.
REQ-011 PRESCALE, default 4, meaning CLK cycles per timer tick (range 1..2^16).

Function
REQ-012 Address map: 0x00-0x77 RAM; 0x78 LED; 0x79 SW; 0x7A TCTRL; 0x7B TSTAT; 0x7C-0x7F reserved.
REQ-013 RAM_CS SHALL equal CS when ADDR<=0x77 and SHALL be 0 otherwise; this path is combinational.
REQ-014 Mem_Bus SHALL be driven with rdata when CS=1, WE=0 and ADDR>=0x78; otherwise it SHALL be high-Z.
REQ-015 rdata SHALL be registered at the falling edge on which CS=1, WE=0 and ADDR>=0x78, giving the same one-half-cycle read latency as the RAM.
REQ-016 Writes SHALL be captured at the falling edge when CS=1, WE=1 and ADDR>=0x78; data is Mem_Bus[31:0].
REQ-017 LED: a write loads Mem_Bus[7:0]; a read returns {24'b0, LED}.
REQ-018 SW: a two-flop synchronizer produces sw_sync; a read returns {24'b0, sw_sync}; writes are ignored.
REQ-019 TCTRL write: bit31 sets EN, bits[15:0] set RELOAD, and COUNT is loaded with RELOAD; TCTRL read returns {EN, 15'b0, RELOAD}.
REQ-020 Prescaler: counts 0..PRESCALE-1 while EN=1; the tick is asserted on the terminal value; the prescaler is cleared whenever EN=0 or TCTRL is written.
REQ-021 On a tick, COUNT SHALL decrement; when a tick occurs with COUNT=1, COUNT SHALL reload to RELOAD and FLAG SHALL set.
REQ-022 If RELOAD=0, the timer SHALL hold COUNT=0 and SHALL never set FLAG.
REQ-023 TSTAT read returns {FLAG, 15'b0, COUNT}; the read clears FLAG; writes to TSTAT are ignored.
REQ-024 If FLAG sets and a TSTAT read occurs on the same edge, FLAG SHALL remain 1.
REQ-025 If a TCTRL write coincides with a tick, the write wins and the tick is dropped.
REQ-026 IRQ SHALL equal FLAG.
REQ-027 Reserved addresses SHALL read 0 and ignore writes.

Reset
REQ-028 With RST=1 at a falling edge: LED=0, EN=0, RELOAD=0, COUNT=0, FLAG=0, prescaler=0, synchronizer=0, rdata=0.
REQ-029 Reset SHALL override any write or read side effect on the same edge.
REQ-030 A reset mid-count SHALL abandon the count with no FLAG.
REQ-031 The bus tristate remains combinational and is unaffected by RST.

Configuration
REQ-032 Macro IO_TIMER_EN: when defined, the timer (REQ-019 to REQ-026) is instantiated.
REQ-033 When IO_TIMER_EN is undefined: 0x7A and 0x7B behave as reserved addresses and IRQ is tied to 0.

Structure
REQ-034 Package mips_io_pkg SHALL hold the address constants (IO_BASE=0x78, LED_A, SW_A, TCTRL_A, TSTAT_A) and the TCTRL bit positions.
REQ-035 Sub-module io_timer SHALL contain the prescaler, COUNT, RELOAD, EN and FLAG.
REQ-036 io_timer interface: write strobe, wdata, read-clear strobe, {EN, RELOAD, COUNT, FLAG} outputs.

Verification
REQ-037 RAM pass-through: CS=1, WE=0, ADDR=0x10 -> RAM_CS=1 and bridge does not drive Mem_Bus; ADDR=0x78 -> RAM_CS=0.
REQ-038 LED: write 0x000000A5 to 0x78, then read 0x78 -> LED=0xA5 and Mem_Bus=0x000000A5.
REQ-039 SW: SW=0x3C held for 3 cycles, then read 0x79 -> 0x0000003C; a write to 0x79 does not change the read value.
REQ-040 Timer: PRESCALE=4, write 0x80000003 to 0x7A -> FLAG sets after 12 CLK cycles; COUNT reloads to 3; IRQ=1; read 0x7B returns 0x80000003 and IRQ=0 afterwards.
REQ-041 Collision: TSTAT read on the same edge as the FLAG set -> FLAG stays 1; RELOAD=0 with EN=1 run for 100 cycles -> FLAG never sets.
REQ-042 Reset mid-operation: assert RST while COUNT=2 -> all registers 0 and IRQ=0; build without IO_TIMER_EN -> 0x7A reads 0 and IRQ=0.
